// File: rtl/gamma_pkg.sv
// Shared definitions for the gamma select path: level range, debouncer states
// and the level -> one-hot select map used by the display decoder and the filter.
package gamma_pkg;

   localparam int unsigned NUM_LEVELS = 10;
   localparam int unsigned LEVEL_W    = 4;
   localparam logic [LEVEL_W-1:0] LEVEL_RESET = 4'd4;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX   = 4'd9;
   localparam logic [LEVEL_W-1:0] LEVEL_MIN   = 4'd0;

   typedef enum logic [1:0] {
      StReleased,
      StPressChk,
      StPressed,
      StReleaseChk
   } deb_state_e;

   // Gamma 1.0 (level 4) owns bit 0 so the decoder's default digit is the neutral one.
   function automatic logic [NUM_LEVELS-1:0] level_to_onehot(input logic [LEVEL_W-1:0] level);
      logic [NUM_LEVELS-1:0] oh;
      case (level)
         4'd0:    oh = 10'b00_0000_0010;
         4'd1:    oh = 10'b00_0000_0100;
         4'd2:    oh = 10'b00_0000_1000;
         4'd3:    oh = 10'b00_0001_0000;
         4'd4:    oh = 10'b00_0000_0001;
         4'd5:    oh = 10'b00_0010_0000;
         4'd6:    oh = 10'b00_0100_0000;
         4'd7:    oh = 10'b00_1000_0000;
         4'd8:    oh = 10'b01_0000_0000;
         4'd9:    oh = 10'b10_0000_0000;
         default: oh = 10'b00_0000_0001;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/gamma_sel_ctrl_if.sv
// Key inputs, frame strobe and gamma select outputs of the gamma selector.
interface gamma_sel_ctrl_if;
   import gamma_pkg::*;

   logic                  key_up_n;
   logic                  key_dn_n;
   logic                  frame_start;
   logic [NUM_LEVELS-1:0] dig;
   logic [LEVEL_W-1:0]    level;
   logic [LEVEL_W-1:0]    pend_level;
   logic                  update;

   modport master (
      output key_up_n, key_dn_n, frame_start,
      input  dig, level, pend_level, update
   );

   modport slave (
      input  key_up_n, key_dn_n, frame_start,
      output dig, level, pend_level, update
   );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchroniser, press/release debounce FSM, one-cycle press event.
module key_debounce
   import gamma_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             sample;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   assign sample = sync_q[1];
   assign press  = press_q;

   // Synchroniser and FSM state; synchronisers reset to the released level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= StReleased;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_n};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   // Debounce next state: a level must stay stable for DEBOUNCE_CYCLES samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      unique case (state_q)
         StReleased: begin
            if (!sample) begin
               state_d = StPressChk;
               cnt_d   = CNT_W'(1);
            end
         end
         StPressChk: begin
            if (sample) begin
               state_d = StReleased;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StPressed;
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPressed: begin
            if (sample) begin
               state_d = StReleaseChk;
               cnt_d   = CNT_W'(1);
            end
         end
         StReleaseChk: begin
            if (!sample) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StReleased;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StReleased;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/gamma_sel_ctrl.sv
// Gamma level selector: debounced UP/DOWN keys move a pending level that is
// applied only at a frame start, so a frame never mixes two gammas.
module gamma_sel_ctrl
   import gamma_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic           clk,
   input  logic           rst,
   gamma_sel_ctrl_if.slave bus
);

   logic                  up_event, dn_event;
   logic [LEVEL_W-1:0]    pending_q, pending_d;
   logic [LEVEL_W-1:0]    level_q, level_d;
   logic [NUM_LEVELS-1:0] dig_q, dig_d;
   logic                  update_q, update_d;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_up (
      .clk  (clk),
      .rst  (rst),
      .key_n(bus.key_up_n),
      .press(up_event)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_dn (
      .clk  (clk),
      .rst  (rst),
      .key_n(bus.key_dn_n),
      .press(dn_event)
   );

   // Saturating pending level; simultaneous UP and DOWN cancel out.
   always_comb begin
      pending_d = pending_q;
      if (up_event && !dn_event && pending_q != LEVEL_MAX) begin
         pending_d = pending_q + 4'd1;
      end else if (dn_event && !up_event && pending_q != LEVEL_MIN) begin
         pending_d = pending_q - 4'd1;
      end
   end

   // Apply at frame start; compares the pending value from before this edge.
   always_comb begin
      level_d  = level_q;
      dig_d    = dig_q;
      update_d = 1'b0;
      if (bus.frame_start && pending_q != level_q) begin
         level_d  = pending_q;
         dig_d    = level_to_onehot(pending_q);
         update_d = 1'b1;
      end
   end

   // Output and level registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= LEVEL_RESET;
         level_q   <= LEVEL_RESET;
         dig_q     <= level_to_onehot(LEVEL_RESET);
         update_q  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         level_q   <= level_d;
         dig_q     <= dig_d;
         update_q  <= update_d;
      end
   end

   assign bus.dig        = dig_q;
   assign bus.level      = level_q;
   assign bus.pend_level = pending_q;
   assign bus.update     = update_q;

endmodule

// File: tb/tb_gamma_sel_ctrl.sv
// Directed bench for gamma_sel_ctrl with a scoreboard of expected apply results.
module tb_gamma_sel_ctrl;

   localparam int unsigned D = 8;

   typedef struct packed {
      logic [3:0] level;
      logic [9:0] dig;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic [3:0] exp_pend;
   logic [3:0] exp_level;

   gamma_sel_ctrl_if bus();

   gamma_sel_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] model_onehot(input logic [3:0] lvl);
      logic [9:0] one;
      one = 10'd1;
      if (lvl == 4'd4) return one;
      else if (lvl < 4'd4) return one << (lvl + 4'd1);
      else return one << lvl;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.key_up_n = 1'b1;
      bus.key_dn_n = 1'b1;
      bus.frame_start = 1'b0;
      tick(3);
      rst = 1'b0;
      sb.delete();
      exp_pend = 4'd4;
      exp_level = 4'd4;
      tick(1);
   endtask

   // Press keys for 'hold' cycles then release cleanly; model updates pending.
   task automatic press(input logic up, input logic dn, input int hold);
      bus.key_up_n = ~up;
      bus.key_dn_n = ~dn;
      tick(hold);
      bus.key_up_n = 1'b1;
      bus.key_dn_n = 1'b1;
      tick(D + 8);
      if (up && !dn && exp_pend != 4'd9) exp_pend = exp_pend + 4'd1;
      else if (dn && !up && exp_pend != 4'd0) exp_pend = exp_pend - 4'd1;
   endtask

   task automatic frame(input string tag);
      bus.frame_start = 1'b1;
      if (exp_pend != exp_level) begin
         sb.push_back('{level: exp_pend, dig: model_onehot(exp_pend)});
         exp_level = exp_pend;
      end
      tick(1);
      bus.frame_start = 1'b0;
      tick(2);
      chk({tag, "_sb_drained"}, 32'(sb.size()), 0);
      chk({tag, "_level"}, 32'(bus.level), 32'(exp_level));
      chk({tag, "_dig"}, 32'(bus.dig), 32'(model_onehot(exp_level)));
   endtask

   // Every update pulse must match the oldest outstanding apply.
   always @(negedge clk) begin
      if (!rst && bus.update) begin
         if (sb.size() == 0) begin
            chk("unexpected_update", 32'(bus.update), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("upd_level", 32'(bus.level), 32'(e.level));
            chk("upd_dig", 32'(bus.dig), 32'(e.dig));
         end
      end
   end

   initial begin
      // 1: reset values, frame start with nothing pending
      do_reset();
      chk("rst_level", 32'(bus.level), 4);
      chk("rst_dig", 32'(bus.dig), 32'h001);
      chk("rst_pend", 32'(bus.pend_level), 4);
      chk("rst_update", 32'(bus.update), 0);
      frame("idle_frame");

      // 2: clean UP press, pending only, then apply
      press(1'b1, 1'b0, 20);
      chk("up_pend", 32'(bus.pend_level), 5);
      chk("up_not_applied", 32'(bus.level), 4);
      frame("up_frame");
      chk("up_dig", 32'(bus.dig), 32'h020);

      // 3: glitch rejection and bouncy release
      do_reset();
      bus.key_up_n = 1'b0;
      tick(5);
      bus.key_up_n = 1'b1;
      tick(D + 8);
      chk("glitch_pend", 32'(bus.pend_level), 4);
      bus.key_up_n = 1'b0;
      tick(20);
      repeat (2) begin
         bus.key_up_n = 1'b1;
         tick(3);
         bus.key_up_n = 1'b0;
         tick(3);
      end
      bus.key_up_n = 1'b1;
      tick(D + 8);
      exp_pend = 4'd5;
      chk("bounce_pend", 32'(bus.pend_level), 32'(exp_pend));

      // 4: saturation at both ends
      do_reset();
      repeat (6) press(1'b0, 1'b1, 12);
      chk("sat_low_pend", 32'(bus.pend_level), 0);
      frame("low_frame");
      chk("low_dig", 32'(bus.dig), 32'h002);
      repeat (11) press(1'b1, 1'b0, 12);
      chk("sat_high_pend", 32'(bus.pend_level), 9);
      frame("high_frame");
      chk("high_dig", 32'(bus.dig), 32'h200);

      // 5: UP event in the same cycle as frame start applies the old pending
      do_reset();
      bus.key_up_n = 1'b0;
      tick(D + 2);
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start = 1'b0;
      bus.key_up_n = 1'b1;
      tick(D + 8);
      exp_pend = 4'd5;
      chk("coinc_pend", 32'(bus.pend_level), 5);
      chk("coinc_level", 32'(bus.level), 4);
      frame("coinc_next_frame");

      // 6: simultaneous presses cancel; reset mid-debounce discards the press
      press(1'b1, 1'b1, 20);
      chk("both_pend", 32'(bus.pend_level), 5);
      bus.key_up_n = 1'b0;
      tick(6);
      rst = 1'b1;
      bus.key_up_n = 1'b1;
      tick(2);
      rst = 1'b0;
      sb.delete();
      exp_pend = 4'd4;
      exp_level = 4'd4;
      tick(D + 12);
      chk("rstmid_pend", 32'(bus.pend_level), 4);
      chk("rstmid_level", 32'(bus.level), 4);
      chk("rstmid_dig", 32'(bus.dig), 32'h001);
      frame("rstmid_frame");

      chk("final_sb_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
